// File: rtl/pool_flatten_pkg.sv
// pool_flatten_pkg
//   Shared definitions for the max-pool / flatten stage: data and address
//   widths, memory select codes, pooling geometry and the FSM state type.
package pool_flatten_pkg;

  localparam int DATAW      = 20;
  localparam int ADDRW      = 12;

  // Memory select codes driven on csel
  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  // Pooled map is POOL_DIM x POOL_DIM; each (pixel, kernel) takes PIX_CYCLES
  localparam int POOL_DIM   = 32;
  localparam int PIX_CYCLES = 7;
  localparam int NUM_PIX    = POOL_DIM * POOL_DIM;
  localparam int PIXW       = $clog2(NUM_PIX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR1  = 3'd3,
    S_WR2  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  function automatic logic [2:0] rd_csel(input logic k);
    return k ? CSEL_L0K1 : CSEL_L0K0;
  endfunction

  function automatic logic [2:0] wr_csel(input logic k);
    return k ? CSEL_L1K1 : CSEL_L1K0;
  endfunction

endpackage

// File: rtl/pool_flatten_if.sv
// pool_flatten_if
//   Bundles the start/done control and the shared testfixture memory port.
//   master: the pool_flatten block; slave: the testfixture / memories.
//   Signals:
//     start      one-cycle start pulse (slave -> master)
//     cdata_rd   read data from the selected memory (slave -> master)
//     crd        read strobe, caddr_rd read address
//     cwr        write strobe, cdata_wr / caddr_wr write data / address
//     csel       memory select code
//     busy, done status; dbg_state exposes the FSM state
//   Strobe semantics: crd / cwr are single-cycle qualifiers with no
//   back-pressure. Address, data and csel are valid in every cycle the
//   matching strobe is high; a read issued in cycle n returns data that is
//   valid for sampling at the rising edge ending cycle n+1.
interface pool_flatten_if;
  import pool_flatten_pkg::*;

  logic             start;
  logic [DATAW-1:0] cdata_rd;
  logic             crd;
  logic [ADDRW-1:0] caddr_rd;
  logic             cwr;
  logic [DATAW-1:0] cdata_wr;
  logic [ADDRW-1:0] caddr_wr;
  logic [2:0]       csel;
  logic             busy;
  logic             done;
  state_t           dbg_state;

  modport master (
    input  start, cdata_rd,
    output crd, caddr_rd, cwr, cdata_wr, caddr_wr, csel, busy, done, dbg_state
  );

  modport slave (
    output start, cdata_rd,
    input  crd, caddr_rd, cwr, cdata_wr, caddr_wr, csel, busy, done, dbg_state
  );

endinterface

// File: rtl/pool_flatten_addr_gen.sv
// pool_addr_gen
//   Owns the pooled-pixel counter p, kernel bit k and window sub-index
//   {dy,dx}, and derives all memory addresses from them.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     i_sub_inc    advance {dy,dx} (wraps 3 -> 0)
//     i_pix_inc    advance k, carrying into p (wraps at p=1023,k=1)
//     o_sub        current {dy,dx}
//     o_k          current kernel
//     o_src_addr   {py, dy, px, dx} into the 64x64 layer-0 map
//     o_l1_addr    {2'b00, p}
//     o_l2_addr    {1'b0, p, k}
//     o_last       high on the final (p,k) pair of a pass
module pool_addr_gen
  import pool_flatten_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sub_inc,
  input  logic             i_pix_inc,
  output logic [1:0]       o_sub,
  output logic             o_k,
  output logic [ADDRW-1:0] o_src_addr,
  output logic [ADDRW-1:0] o_l1_addr,
  output logic [ADDRW-1:0] o_l2_addr,
  output logic             o_last
);

  logic [PIXW-1:0] r_p;
  logic            r_k;
  logic [1:0]      r_sub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p   <= '0;
      r_k   <= 1'b0;
      r_sub <= 2'd0;
    end else begin
      if (i_sub_inc) r_sub <= r_sub + 2'd1;
      if (i_pix_inc) begin
        // Kernel is the inner loop: p only advances after k=1
        r_k <= ~r_k;
        if (r_k) r_p <= r_p + 1'b1;
      end
    end
  end

  assign o_sub      = r_sub;
  assign o_k        = r_k;
  // p = {py, px}; the source pixel is row 2py+dy, column 2px+dx of 64
  assign o_src_addr = {r_p[PIXW-1:PIXW/2], r_sub[1], r_p[PIXW/2-1:0], r_sub[0]};
  assign o_l1_addr  = {2'b00, r_p};
  assign o_l2_addr  = {1'b0, r_p, r_k};
  assign o_last     = (r_p == PIXW'(NUM_PIX - 1)) && r_k;

endmodule

// File: rtl/pool_flatten.sv
// pool_flatten
//   2x2 stride-2 signed max pooling of the two 64x64 layer-0 maps into the
//   32x32 layer-1 maps, plus the interleaved 2048-entry layer-2 vector.
//   Each (p,k) takes 7 cycles: RD x4, WAIT, WR1 (L1), WR2 (L2).
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    pool_flatten_if.master (start, memory port, busy/done, state)
module pool_flatten
  import pool_flatten_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  pool_flatten_if.master bus
);

  state_t           r_state;
  logic             r_crd;
  logic             r_cwr;
  logic             r_busy;
  logic             r_done;
  logic             r_last;
  logic [2:0]       r_csel;
  logic [ADDRW-1:0] r_caddr_rd;
  logic [ADDRW-1:0] r_caddr_wr;
  logic [DATAW-1:0] r_cdata_wr;
  logic [DATAW-1:0] r_max;

  logic [1:0]       w_sub;
  logic             w_k;
  logic [ADDRW-1:0] w_src_addr;
  logic [ADDRW-1:0] w_l1_addr;
  logic [ADDRW-1:0] w_l2_addr;
  logic             w_last;
  logic             w_sub_inc;
  logic             w_pix_inc;
  logic             w_cap;
  logic             w_first;
  logic [DATAW-1:0] w_max_next;

  // The sub counter holds the index of the next read to issue, so it is
  // bumped on every edge that registers a new read address. In RD it reads
  // 1,2,3,0 for reads 0..3; sub==0 in RD marks the cycle issuing read 3.
  assign w_sub_inc = ((r_state == S_IDLE) && bus.start) ||
                     ((r_state == S_RD) && (w_sub != 2'd0)) ||
                     ((r_state == S_WR2) && !r_last);
  // Advancing (p,k) during WR1 lets WR2 launch the next read directly from
  // the counters; the L2 address for WR2 is registered on that same edge.
  assign w_pix_inc = (r_state == S_WR1);

  pool_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_sub_inc  (w_sub_inc),
    .i_pix_inc  (w_pix_inc),
    .o_sub      (w_sub),
    .o_k        (w_k),
    .o_src_addr (w_src_addr),
    .o_l1_addr  (w_l1_addr),
    .o_l2_addr  (w_l2_addr),
    .o_last     (w_last)
  );

  // Read j lands at the end of the cycle after it was issued: reads 0..2
  // are captured during the RD cycles for reads 1..3, read 3 during WAIT.
  assign w_cap   = ((r_state == S_RD) && (w_sub != 2'd1)) || (r_state == S_WAIT);
  assign w_first = (r_state == S_RD) && (w_sub == 2'd2);
  // Strict greater-than keeps the earlier sample on a tie
  assign w_max_next = (w_first || ($signed(bus.cdata_rd) > $signed(r_max))) ?
                      bus.cdata_rd : r_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= 1'b0;
      r_csel     <= CSEL_NONE;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_max      <= '0;
    end else begin
      if (w_cap) r_max <= w_max_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RD;
            r_busy     <= 1'b1;
            r_crd      <= 1'b1;
            r_csel     <= rd_csel(w_k);
            r_caddr_rd <= w_src_addr;
          end
        end
        S_RD: begin
          if (w_sub == 2'd0) begin
            r_state <= S_WAIT;
            r_crd   <= 1'b0;
          end else begin
            r_caddr_rd <= w_src_addr;
          end
        end
        S_WAIT: begin
          r_state    <= S_WR1;
          r_cwr      <= 1'b1;
          r_csel     <= wr_csel(w_k);
          r_caddr_wr <= w_l1_addr;
          r_cdata_wr <= w_max_next;
        end
        S_WR1: begin
          r_state    <= S_WR2;
          r_csel     <= CSEL_L2;
          r_caddr_wr <= w_l2_addr;
          r_last     <= w_last;
        end
        S_WR2: begin
          r_cwr <= 1'b0;
          if (r_last) begin
            r_state <= S_FIN;
            r_csel  <= CSEL_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_last  <= 1'b0;
          end else begin
            // Counters already point at the next (p,k)
            r_state    <= S_RD;
            r_crd      <= 1'b1;
            r_csel     <= rd_csel(w_k);
            r_caddr_rd <= w_src_addr;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.crd       = r_crd;
  assign bus.caddr_rd  = r_caddr_rd;
  assign bus.cwr       = r_cwr;
  assign bus.cdata_wr  = r_cdata_wr;
  assign bus.caddr_wr  = r_caddr_wr;
  assign bus.csel      = r_csel;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pool_flatten.sv
// tb_pool_flatten
//   Bench for pool_flatten: behavioural memories, a reference model that
//   computes every expected read and write of a pass, and a monitor that
//   checks the DUT's memory traffic against those expectations.
module tb_pool_flatten;
  import pool_flatten_pkg::*;

  localparam int DONE_LAT = 14337;
  localparam int LIMIT    = 20000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pool_flatten_if u_if ();

  pool_flatten u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  // ---------------- memories and model state ----------------
  logic [DATAW-1:0] l0k0 [4096];
  logic [DATAW-1:0] l0k1 [4096];
  logic [DATAW-1:0] l1k0 [1024];
  logic [DATAW-1:0] l1k1 [1024];
  logic [DATAW-1:0] l2   [2048];
  logic [DATAW-1:0] exp_l1k0 [1024];
  logic [DATAW-1:0] exp_l1k1 [1024];
  logic [DATAW-1:0] exp_l2   [2048];
  logic [DATAW-1:0] sav_l1k0 [1024];
  logic [DATAW-1:0] sav_l1k1 [1024];
  logic [DATAW-1:0] sav_l2   [2048];

  logic [14:0] exp_rd_q [$];   // {csel, addr}
  logic [34:0] exp_wr_q [$];   // {csel, addr, data}

  int n_checks = 0;
  int n_fail   = 0;
  int rd_count = 0;
  int wr_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_crd"},      64'(u_if.crd), 0);
    check({name, "_cwr"},      64'(u_if.cwr), 0);
    check({name, "_csel"},     64'(u_if.csel), 0);
    check({name, "_busy"},     64'(u_if.busy), 0);
    check({name, "_done"},     64'(u_if.done), 0);
    check({name, "_caddr_rd"}, 64'(u_if.caddr_rd), 0);
    check({name, "_caddr_wr"}, 64'(u_if.caddr_wr), 0);
    check({name, "_cdata_wr"}, 64'(u_if.cdata_wr), 0);
  endtask

  // ---------------- memory model (samples at falling edges) ----------------
  logic             rd_pend = 1'b0;
  logic [2:0]       rd_sel_q;
  logic [ADDRW-1:0] rd_addr_q;

  always @(negedge clk) begin
    if (reset) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend)
        u_if.cdata_rd = (rd_sel_q == CSEL_L0K1) ? l0k1[rd_addr_q] : l0k0[rd_addr_q];
      rd_pend   = u_if.crd;
      rd_sel_q  = u_if.csel;
      rd_addr_q = u_if.caddr_rd;
      if (u_if.cwr) begin
        case (u_if.csel)
          CSEL_L1K0: l1k0[u_if.caddr_wr[9:0]] = u_if.cdata_wr;
          CSEL_L1K1: l1k1[u_if.caddr_wr[9:0]] = u_if.cdata_wr;
          CSEL_L2:   l2[u_if.caddr_wr[10:0]]  = u_if.cdata_wr;
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_crd  = 1'b0;
  logic [2:0] prev_csel = 3'd0;

  always @(negedge clk) begin
    if (reset) begin
      prev_crd = 1'b0;
    end else begin
      check("rd_wr_exclusive", 64'(u_if.crd & u_if.cwr), 0);
      check("cwr_vs_csel", 64'(u_if.cwr),
            64'(u_if.csel == CSEL_L1K0 || u_if.csel == CSEL_L1K1 || u_if.csel == CSEL_L2));
      if (prev_crd) check("csel_hold", 64'(u_if.csel), 64'(prev_csel));
      if (u_if.crd) begin
        rd_count++;
        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'({u_if.csel, u_if.caddr_rd}), 64'h7fff_ffff);
        else check("rd_addr", 64'({u_if.csel, u_if.caddr_rd}), 64'(exp_rd_q.pop_front()));
      end
      if (u_if.cwr) begin
        wr_count++;
        if (exp_wr_q.size() == 0)
          check("wr_unexpected", 64'({u_if.csel, u_if.caddr_wr, u_if.cdata_wr}), 64'h7_ffff_ffff_ffff);
        else
          check("wr_data", 64'({u_if.csel, u_if.caddr_wr, u_if.cdata_wr}), 64'(exp_wr_q.pop_front()));
      end
      prev_crd  = u_if.crd;
      prev_csel = u_if.csel;
    end
  end

  // ---------------- reference model ----------------
  // Walks the pooled map directly: each output is the signed maximum of its
  // 2x2 window, and the traffic is listed in the order the pass produces it.
  task automatic build_expect();
    int a, v, best, p;
    logic [DATAW-1:0] data;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int py = 0; py < POOL_DIM; py++) begin
      for (int px = 0; px < POOL_DIM; px++) begin
        for (int k = 0; k < 2; k++) begin
          best = 0;
          for (int s = 0; s < 4; s++) begin
            a = (2 * py + s / 2) * 64 + 2 * px + s % 2;
            v = (k == 1) ? $signed(l0k1[a]) : $signed(l0k0[a]);
            exp_rd_q.push_back({(k == 1) ? CSEL_L0K1 : CSEL_L0K0, 12'(a)});
            if (s == 0 || v > best) best = v;
          end
          p    = py * POOL_DIM + px;
          data = DATAW'(best);
          exp_wr_q.push_back({(k == 1) ? CSEL_L1K1 : CSEL_L1K0, 12'(p), data});
          exp_wr_q.push_back({CSEL_L2, 12'(2 * p + k), data});
          if (k == 1) exp_l1k1[p] = data;
          else        exp_l1k0[p] = data;
          exp_l2[2 * p + k] = data;
        end
      end
    end
  endtask

  function automatic logic [DATAW-1:0] rand_word();
    if ($urandom_range(0, 3) == 0) return DATAW'($urandom_range(0, 3));
    return DATAW'($urandom);
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 4096; a++) begin
      l0k0[a] = rand_word();
      l0k1[a] = rand_word();
    end
  endtask

  task automatic mem_compare(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (l1k0[i] !== exp_l1k0[i]) errs++;
      if (l1k1[i] !== exp_l1k1[i]) errs++;
    end
    for (int i = 0; i < 2048; i++) if (l2[i] !== exp_l2[i]) errs++;
    check(name, 64'(errs), 0);
  endtask

  // ---------------- driver ----------------
  task automatic run_pass(input int busy_at);
    int n;
    build_expect();
    rd_count = 0;
    wr_count = 0;
    @(negedge clk) u_if.start = 1'b1;
    @(negedge clk) u_if.start = 1'b0;
    n = 1;
    check("busy_after_start", 64'(u_if.busy), 1);
    while (!u_if.done && n < LIMIT) begin
      @(negedge clk);
      n++;
      u_if.start = (n == busy_at);
    end
    u_if.start = 1'b0;
    check("done_latency", 64'(n), 64'(DONE_LAT));
    check("busy_at_done", 64'(u_if.busy), 0);
    @(negedge clk);
    check("done_one_cycle", 64'(u_if.done), 0);
    check("idle_after_fin", 64'(u_if.dbg_state), 64'(S_IDLE));
    check("read_count", 64'(rd_count), 8192);
    check("write_count", 64'(wr_count), 4096);
    check("queues_drained", 64'(exp_rd_q.size() + exp_wr_q.size()), 0);
  endtask

  initial begin
    u_if.start    = 1'b0;
    u_if.cdata_rd = '0;
    for (int i = 0; i < 1024; i++) begin l1k0[i] = '0; l1k1[i] = '0; end
    for (int i = 0; i < 2048; i++) l2[i] = '0;

    repeat (3) @(negedge clk);
    check_zero("in_reset");
    check("state_in_reset", 64'(u_if.dbg_state), 64'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check_zero("after_reset");

    // Ramp pass
    for (int a = 0; a < 4096; a++) begin
      l0k0[a] = DATAW'(a);
      l0k1[a] = DATAW'(4095 - a);
    end
    run_pass(0);
    check("ramp_l1k0_0",    64'(l1k0[0]),    65);
    check("ramp_l1k0_1023", 64'(l1k0[1023]), 4095);
    check("ramp_l1k1_0",    64'(l1k1[0]),    4095);
    check("ramp_l1k1_1023", 64'(l1k1[1023]), 65);
    check("ramp_l2_0",      64'(l2[0]),      65);
    check("ramp_l2_1",      64'(l2[1]),      4095);
    check("ramp_l2_2046",   64'(l2[2046]),   4095);
    check("ramp_l2_2047",   64'(l2[2047]),   65);
    mem_compare("ramp_mem");

    // Random data with signed / tie / extreme windows, start pulsed while busy
    fill_random();
    l0k0[0] = 20'hFFFFB; l0k0[1] = 20'hFFFFD; l0k0[64] = 20'hFFFFD; l0k0[65] = 20'hFFFF9;
    l0k0[2] = 20'h7FFFF; l0k0[3] = 20'h80000; l0k0[66] = 20'h00000; l0k0[67] = 20'h00001;
    run_pass(1000);
    check("signed_l1k0_0",  64'(l1k0[0]), 64'h0FFFFD);
    check("extreme_l1k0_1", 64'(l1k0[1]), 64'h07FFFF);
    check("signed_l2_0",    64'(l2[0]),   64'h0FFFFD);
    check("extreme_l2_2",   64'(l2[2]),   64'h07FFFF);
    mem_compare("random_mem");

    // Second start after done reproduces identical results
    for (int i = 0; i < 1024; i++) begin
      sav_l1k0[i] = l1k0[i]; sav_l1k1[i] = l1k1[i];
      l1k0[i] = DATAW'($urandom); l1k1[i] = DATAW'($urandom);
    end
    for (int i = 0; i < 2048; i++) begin
      sav_l2[i] = l2[i];
      l2[i] = DATAW'($urandom);
    end
    run_pass(0);
    begin
      int errs;
      errs = 0;
      for (int i = 0; i < 1024; i++) begin
        if (l1k0[i] !== sav_l1k0[i]) errs++;
        if (l1k1[i] !== sav_l1k1[i]) errs++;
      end
      for (int i = 0; i < 2048; i++) if (l2[i] !== sav_l2[i]) errs++;
      check("repeat_identical", 64'(errs), 0);
    end

    // Asynchronous reset mid-pass
    fill_random();
    build_expect();
    @(negedge clk) u_if.start = 1'b1;
    @(negedge clk) u_if.start = 1'b0;
    repeat (499) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_zero("async_reset");
    check("state_async_reset", 64'(u_if.dbg_state), 64'(S_IDLE));
    exp_rd_q.delete();
    exp_wr_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd_count = 0;
    wr_count = 0;
    repeat (200) @(negedge clk);
    check("no_rd_after_reset", 64'(rd_count), 0);
    check("no_wr_after_reset", 64'(wr_count), 0);
    check("idle_after_reset", 64'(u_if.busy), 0);

    // Full pass after the interrupted one
    fill_random();
    run_pass(0);
    mem_compare("recovery_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
